// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared encodings and alignment check for the data memory controller
// Contents: access size codes, FSM state codes, alignFault() helper.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // 1 when the access size cannot be served at this byte offset.
    // The reserved size code always faults.
    function automatic logic alignFault(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - request/response bus between the MEM stage and the data memory
// Signals: req/we/size/sign_ext/addr/wdata from the requester;
//          rdata/ready/fault/busy back from the memory controller.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;
    logic              fault;
    logic              busy;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  rdata, ready, fault, busy
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output rdata, ready, fault, busy
    );
endinterface

// File: rtl/data_mem_lane_align.sv
// rtl/data_mem_lane_align.sv - big-endian byte-lane steering for stores and loads
// Inputs : offset (addr[1:0]), size, signExt, memWord (stored word), storeData (right-justified)
// Outputs: laneEn (bit i covers bits 8i+7:8i), laneData (store data placed on lanes),
//          loadData (extracted and extended load value)
module data_mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        signExt,
    input  logic [31:0] memWord,
    input  logic [31:0] storeData,
    output logic [3:0]  laneEn,
    output logic [31:0] laneData,
    output logic [31:0] loadData
);

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    always_comb begin
        loadByte = 8'h00;
        case (offset)
            2'd0:    loadByte = memWord[31:24];
            2'd1:    loadByte = memWord[23:16];
            2'd2:    loadByte = memWord[15:8];
            default: loadByte = memWord[7:0];
        endcase
        // Misaligned halves are faulted upstream, so only offset[1] matters here.
        loadHalf = offset[1] ? memWord[15:0] : memWord[31:16];

        laneEn   = 4'b0000;
        laneData = 32'h0;
        loadData = 32'h0;
        case (size)
            SZ_BYTE: begin
                // Offset 0 is the most significant lane.
                laneEn   = 4'b1000 >> offset;
                laneData = {4{storeData[7:0]}};
                loadData = {{24{signExt & loadByte[7]}}, loadByte};
            end
            SZ_HALF: begin
                laneEn   = offset[1] ? 4'b0011 : 4'b1100;
                laneData = {2{storeData[15:0]}};
                loadData = {{16{signExt & loadHalf[15]}}, loadHalf};
            end
            SZ_WORD: begin
                laneEn   = 4'b1111;
                laneData = storeData;
                loadData = memWord;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - multi-cycle data memory with sized access, wait states and fault reporting
// Ports: CLK, RST (async, active high), bus (slave side of data_mem_ctrl_if).
// The request is captured at acceptance; all fault checks and the store commit use the
// captured copy, and the store is written on the same edge that ends the ready cycle.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic           CLK,
    input  logic           RST,
    data_mem_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    logic [1:0]        state;
    logic [CNT_W-1:0]  waitCnt;
    logic              capWe;
    logic              capSignExt;
    logic [1:0]        capSize;
    logic [ADDR_W-1:0] capAddr;
    logic [31:0]       capWdata;
    logic [31:0]       mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  capIdx;
    logic              rangeFault;
    logic              accessFault;
    logic              inResp;
    logic [3:0]        laneEn;
    logic [31:0]       laneData;
    logic [31:0]       loadData;

    assign capIdx      = capAddr[IDX_W+1:2];
    // Any address bit above the word index makes the access out of range.
    assign rangeFault  = (capAddr >> (IDX_W + 2)) != '0;
    assign accessFault = alignFault(capSize, capAddr[1:0]) | rangeFault;
    assign inResp      = (state == S_RESP);

    data_mem_lane_align u_lane (
        .offset    (capAddr[1:0]),
        .size      (capSize),
        .signExt   (capSignExt),
        .memWord   (mem[capIdx]),
        .storeData (capWdata),
        .laneEn    (laneEn),
        .laneData  (laneData),
        .loadData  (loadData)
    );

    assign bus.ready = inResp;
    assign bus.fault = inResp & accessFault;
    assign bus.rdata = (inResp && !capWe && !accessFault) ? loadData : 32'h0;
    assign bus.busy  = (state != S_IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            waitCnt    <= '0;
            capWe      <= 1'b0;
            capSignExt <= 1'b0;
            capSize    <= SZ_BYTE;
            capAddr    <= '0;
            capWdata   <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        capWe      <= bus.we;
                        capSignExt <= bus.sign_ext;
                        capSize    <= bus.size;
                        capAddr    <= bus.addr;
                        capWdata   <= bus.wdata;
                        waitCnt    <= '0;
                        state      <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (waitCnt == WAIT_LAST) begin
                        state <= S_RESP;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage array; a reset mid-access clears it before any pending store could commit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (inResp && capWe && !accessFault) begin
            for (int l = 0; l < 4; l++) begin
                if (laneEn[l]) begin
                    mem[capIdx][8*l +: 8] <= laneData[8*l +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl (WAIT_STATES 0 and 3)
module tb_data_mem_ctrl;
    import data_mem_pkg::*;

    logic CLK = 1'b0;
    logic rst0;
    logic rst3;

    always #5 CLK = ~CLK;

    data_mem_ctrl_if #(.ADDR_W(32)) if0 ();
    data_mem_ctrl_if #(.ADDR_W(32)) if3 ();

    data_mem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(0), .ADDR_W(32)) u0 (
        .CLK (CLK),
        .RST (rst0),
        .bus (if0.slave)
    );

    data_mem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(3), .ADDR_W(32)) u3 (
        .CLK (CLK),
        .RST (rst3),
        .bus (if3.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rq, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            if3.req = rq; if3.we = w; if3.size = sz; if3.sign_ext = sx; if3.addr = a; if3.wdata = wd;
        end else begin
            if0.req = rq; if0.we = w; if0.size = sz; if0.sign_ext = sx; if0.addr = a; if0.wdata = wd;
        end
    endtask

    function automatic logic rdyOf(input bit sel);
        return sel ? if3.ready : if0.ready;
    endfunction
    function automatic logic fltOf(input bit sel);
        return sel ? if3.fault : if0.fault;
    endfunction
    function automatic logic busyOf(input bit sel);
        return sel ? if3.busy : if0.busy;
    endfunction
    function automatic logic [31:0] rdOf(input bit sel);
        return sel ? if3.rdata : if0.rdata;
    endfunction

    // One request: push expectation, drive for one edge, then watch a fixed window.
    // With pulseReq, a conflicting word store is requested every cycle the DUT is busy.
    task automatic access(input bit sel, input string tag, input logic w, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] expRd, input logic expF, input bit pulseReq);
        exp_t e;
        exp_t got;
        int   lat = 0;
        int   nReady = 0;
        e.tag = tag; e.rdata = expRd; e.fault = expF;
        sbq.push_back(e);
        @(negedge CLK);
        drive(sel, 1'b1, w, sz, sx, a, wd);
        @(posedge CLK); #1;
        drive(sel, 1'b0, w, sz, sx, a, wd);
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            if (rdyOf(sel)) begin
                nReady++;
                if (nReady == 1) begin
                    lat = i;
                    check({tag, "_sb_depth"}, 32'(sbq.size()), 32'd1);
                    if (sbq.size() != 0) begin
                        got = sbq.pop_front();
                        check({got.tag, "_rdata"}, rdOf(sel), got.rdata);
                        check({got.tag, "_fault"}, {31'b0, fltOf(sel)}, {31'b0, got.fault});
                    end
                end
            end
            if (pulseReq && busyOf(sel)) drive(sel, 1'b1, 1'b1, SZ_WORD, 1'b0, a, 32'hDEADBEEF);
            @(posedge CLK); #1;
            drive(sel, 1'b0, w, sz, sx, a, wd);
        end
        check({tag, "_ready_count"}, 32'(nReady), 32'd1);
        check({tag, "_latency"}, 32'(lat), sel ? 32'd4 : 32'd1);
        check({tag, "_busy_idle"}, {31'b0, busyOf(sel)}, 32'd0);
    endtask

    initial begin
        int nRdy;
        rst0 = 1'b1;
        rst3 = 1'b1;
        drive(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ready0", {31'b0, if0.ready}, 32'd0);
        check("rst_fault0", {31'b0, if0.fault}, 32'd0);
        check("rst_busy0",  {31'b0, if0.busy},  32'd0);
        check("rst_rdata0", if0.rdata, 32'd0);
        check("rst_ready3", {31'b0, if3.ready}, 32'd0);
        check("rst_busy3",  {31'b0, if3.busy},  32'd0);
        rst0 = 1'b0;
        rst3 = 1'b0;

        // Zero wait states: sized accesses, extension, alignment and range faults.
        access(0, "st_w4",    1, SZ_WORD, 0, 32'h4,   32'h12345678, 32'h0,        0, 0);
        access(0, "ld_w4",    0, SZ_WORD, 0, 32'h4,   32'h0,        32'h12345678, 0, 0);
        access(0, "st_b5",    1, SZ_BYTE, 0, 32'h5,   32'hAAAAAAF0, 32'h0,        0, 0);
        access(0, "ld_b5_sx", 0, SZ_BYTE, 1, 32'h5,   32'h0,        32'hFFFFFFF0, 0, 0);
        access(0, "ld_b5_zx", 0, SZ_BYTE, 0, 32'h5,   32'h0,        32'h000000F0, 0, 0);
        access(0, "ld_w4_b",  0, SZ_WORD, 0, 32'h4,   32'h0,        32'h12F05678, 0, 0);
        access(0, "ld_h6_sx", 0, SZ_HALF, 1, 32'h6,   32'h0,        32'h00005678, 0, 0);
        access(0, "ld_h4_sx", 0, SZ_HALF, 1, 32'h4,   32'h0,        32'h000012F0, 0, 0);
        access(0, "st_h3",    1, SZ_HALF, 0, 32'h3,   32'hFFFFFFFF, 32'h0,        1, 0);
        access(0, "ld_w4_c",  0, SZ_WORD, 0, 32'h4,   32'h0,        32'h12F05678, 0, 0);
        access(0, "ld_w0",    0, SZ_WORD, 0, 32'h0,   32'h0,        32'h0,        0, 0);
        access(0, "st_w6_mis",1, SZ_WORD, 0, 32'h6,   32'h0,        32'h0,        1, 0);
        access(0, "ld_rsv",   0, 2'b11,   0, 32'h4,   32'h0,        32'h0,        1, 0);
        access(0, "ld_w100",  0, SZ_WORD, 0, 32'h100, 32'h0,        32'h0,        1, 0);
        access(0, "st_wfc",   1, SZ_WORD, 0, 32'hFC,  32'hA5A5C3C3, 32'h0,        0, 0);
        access(0, "ld_wfc",   0, SZ_WORD, 0, 32'hFC,  32'h0,        32'hA5A5C3C3, 0, 0);
        access(0, "st_h6",    1, SZ_HALF, 0, 32'h6,   32'h12348001, 32'h0,        0, 0);
        access(0, "ld_h6_neg",0, SZ_HALF, 1, 32'h6,   32'h0,        32'hFFFF8001, 0, 0);
        access(0, "ld_h6_zx", 0, SZ_HALF, 0, 32'h6,   32'h0,        32'h00008001, 0, 0);
        access(0, "st_b7",    1, SZ_BYTE, 0, 32'h7,   32'h00000099, 32'h0,        0, 0);
        access(0, "ld_w4_d",  0, SZ_WORD, 1, 32'h4,   32'h0,        32'h12F08099, 0, 0);

        // Three wait states: latency, ignored requests while busy.
        access(1, "st3_w8",   1, SZ_WORD, 0, 32'h8,   32'hCAFEBABE, 32'h0,        0, 0);
        access(1, "ld3_w8_p", 0, SZ_WORD, 0, 32'h8,   32'h0,        32'hCAFEBABE, 0, 1);
        access(1, "ld3_w8",   0, SZ_WORD, 0, 32'h8,   32'h0,        32'hCAFEBABE, 0, 0);

        // Reset two cycles into a store: outputs drop at once, no ready, store lost.
        @(negedge CLK);
        drive(1'b1, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h8, 32'h55AA55AA);
        @(posedge CLK); #1;
        drive(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h8, 32'h55AA55AA);
        @(posedge CLK); #1;
        check("rstmid_busy_before", {31'b0, if3.busy}, 32'd1);
        @(posedge CLK); #1;
        rst3 = 1'b1;
        #1;
        check("rstmid_ready", {31'b0, if3.ready}, 32'd0);
        check("rstmid_busy",  {31'b0, if3.busy},  32'd0);
        check("rstmid_fault", {31'b0, if3.fault}, 32'd0);
        check("rstmid_rdata", if3.rdata, 32'd0);
        repeat (2) @(negedge CLK);
        rst3 = 1'b0;
        nRdy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (if3.ready) nRdy++;
        end
        check("rstmid_no_ready", 32'(nRdy), 32'd0);
        access(1, "ld3_w8_rst", 0, SZ_WORD, 0, 32'h8, 32'h0, 32'h0, 0, 0);

        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
